wb_mem_arbiter: RTL

- Arbitrates the I-cache and D-cache wishbone master ports (line-miss/writeback traffic) onto the single wishbone memory port.
- Sits between the two L1 caches and physical memory; holds the grant for a whole bus cycle.
- Round-robin fairness on ties, with a burst limit so neither cache starves the other.
- Owner selection and return-path gating are registered; the memory-side mux is combinational from the registered owner.

---
 rtl/wb_mem_arbiter_if.sv | 20 ++
 rtl/wb_mem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter_if.sv
// Wishbone line-transfer bundle shared by the cache ports and the memory port.
// The master side drives the cycle controls; the slave side returns termination and read data.
interface wb_mem_arbiter_if #(
  parameter int ADR_WIDTH = 12,
  parameter int DAT_WIDTH = 128,
  parameter int SEL_WIDTH = 16
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADR_WIDTH-1:0] adr;
  logic [SEL_WIDTH-1:0] sel;
  logic [DAT_WIDTH-1:0] dat_m;
  logic                 ack;
  logic                 rty;
  logic [DAT_WIDTH-1:0] dat_s;

  modport master (output cyc, stb, we, adr, sel, dat_m, input ack, rty, dat_s);
  modport slave  (input cyc, stb, we, adr, sel, dat_m, output ack, rty, dat_s);
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-way wishbone arbiter: I-cache and D-cache onto one memory port, round-robin
// on ties, tenure held for a whole bus cycle with a transfer-count preemption limit.
//
// state | meaning
// IDLE  | no owner, memory port quiet, arbitrating
// OWN_I | I-cache owns the memory port
// OWN_D | D-cache owns the memory port
module wb_mem_arbiter #(
  parameter int ADR_WIDTH = 12,
  parameter int DAT_WIDTH = 128,
  parameter int SEL_WIDTH = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wb_mem_arbiter_if.slave         i_bus,
  wb_mem_arbiter_if.slave         d_bus,
  wb_mem_arbiter_if.master        mem_bus,
  output logic                    grant_i,
  output logic                    grant_d
);
  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  state_t           state;
  logic             last_owner_d;
  logic [CNT_W-1:0] burst_cnt;
  logic             req_i;
  logic             req_d;
  logic             term;
  logic             burst_end;

  assign req_i = i_bus.cyc & i_bus.stb;
  assign req_d = d_bus.cyc & d_bus.stb;
  assign term  = (mem_bus.ack | mem_bus.rty) & mem_bus.stb;
  // Once saturated, the next termination still counts as a burst boundary.
  assign burst_end = (MAX_BURST != 0) && term && (burst_cnt >= BURST_LAST);

  assign i_bus.dat_s = mem_bus.dat_s;
  assign d_bus.dat_s = mem_bus.dat_s;

  always_comb begin
    mem_bus.cyc   = 1'b0;
    mem_bus.stb   = 1'b0;
    mem_bus.we    = 1'b0;
    mem_bus.adr   = '0;
    mem_bus.sel   = '0;
    mem_bus.dat_m = '0;
    i_bus.ack     = 1'b0;
    i_bus.rty     = 1'b0;
    d_bus.ack     = 1'b0;
    d_bus.rty     = 1'b0;
    case (state)
      OWN_I: begin
        mem_bus.cyc   = i_bus.cyc;
        mem_bus.stb   = i_bus.stb;
        mem_bus.we    = i_bus.we;
        mem_bus.adr   = i_bus.adr;
        mem_bus.sel   = i_bus.sel;
        mem_bus.dat_m = i_bus.dat_m;
        i_bus.ack     = mem_bus.ack;
        i_bus.rty     = mem_bus.rty;
      end
      OWN_D: begin
        mem_bus.cyc   = d_bus.cyc;
        mem_bus.stb   = d_bus.stb;
        mem_bus.we    = d_bus.we;
        mem_bus.adr   = d_bus.adr;
        mem_bus.sel   = d_bus.sel;
        mem_bus.dat_m = d_bus.dat_m;
        d_bus.ack     = mem_bus.ack;
        d_bus.rty     = mem_bus.rty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_owner_d <= 1'b1;
      burst_cnt    <= '0;
      grant_i      <= 1'b0;
      grant_d      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (req_i && (!req_d || last_owner_d)) begin
            state   <= OWN_I;
            grant_i <= 1'b1;
          end else if (req_d) begin
            state   <= OWN_D;
            grant_d <= 1'b1;
          end
        end
        OWN_I: begin
          if (term && (burst_cnt != BURST_MAX)) burst_cnt <= burst_cnt + CNT_W'(1);
          if (!i_bus.cyc || (burst_end && req_d)) begin
            state        <= IDLE;
            grant_i      <= 1'b0;
            last_owner_d <= 1'b0;
          end
        end
        OWN_D: begin
          if (term && (burst_cnt != BURST_MAX)) burst_cnt <= burst_cnt + CNT_W'(1);
          if (!d_bus.cyc || (burst_end && req_i)) begin
            state        <= IDLE;
            grant_d      <= 1'b0;
            last_owner_d <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_i <= 1'b0;
          grant_d <= 1'b0;
        end
      endcase
    end
  end
endmodule
